// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Single-port word memory behind a request/response handshake with a
//   configurable wait-state count. It handles RV32 load/store widths
//   (B/H/W/BU/HU), byte-lane writes, load extension and access-fault
//   detection.
//
// Handshake: a request is accepted on the rising edge where
//   req_valid && req_ready. req_ready is high only while the controller
//   is idle, so at most one access is in flight. Requests presented
//   while req_ready is low are ignored and must be held by the
//   requester. Each accepted request produces exactly one rsp_valid
//   pulse. rsp_rdata and rsp_err are meaningful only while rsp_valid
//   is high, and are driven to zero at all other times.
//
// Parameters:
//   DEPTH      memory size in 32-bit words (power of two, 4..65536)
//   WAIT       extra wait cycles per access (0..15)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   req_valid  request present
//   req_ready  controller can accept a request (idle)
//   req_we     1 = store, 0 = load
//   req_size   RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr   byte address
//   req_wdata  store data, right-aligned
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load result, extended to 32 bits
//   rsp_err    access fault, qualified by rsp_valid
//   dbg_state  current FSM state (debug observation)
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAITING = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        run_q;      // low while in reset, high from the first edge after release
    logic        lat_we;
    logic [2:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Contents survive reset; they are zero only at time zero.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    // Fault rules: misalignment, out-of-range word, illegal funct3
    // (unsigned widths are load-only).
    function automatic logic is_fault(input logic we, input logic [2:0] size,
                                      input logic [31:0] addr);
        logic bad;
        case (size)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = |addr[1:0];
            3'b100:  bad = we;
            3'b101:  bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        if (addr[31:2] >= 30'(DEPTH)) bad = 1'b1;
        return bad;
    endfunction

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [2:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_fault;
    logic        lat_fault;

    assign req_ready = (state == S_IDLE) && run_q;
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // The store commits on the edge entering RESP. With WAIT = 0 that edge
    // is also the accept edge, so the request fields come straight from
    // the inputs instead of the latches.
    assign cur_we    = (state == S_IDLE) ? req_we    : lat_we;
    assign cur_size  = (state == S_IDLE) ? req_size  : lat_size;
    assign cur_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;

    assign enter_resp = ((state == S_IDLE) && accept && (WAIT_INIT == 4'd0)) ||
                        ((state == S_WAITING) && (cnt == 4'd1));

    assign cur_fault = is_fault(cur_we, cur_size, cur_addr);
    assign lat_fault = is_fault(lat_we, lat_size, lat_addr);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            run_q     <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            run_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (WAIT_INIT == 4'd0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAITING;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAITING: begin
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- store path ----------------
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        mem_we;
    logic [AW-1:0] wr_idx;

    always_comb begin
        wr_data = cur_wdata << {cur_addr[1:0], 3'b000};
        case (cur_size[1:0])
            2'b00:   wr_be = 4'b0001 << cur_addr[1:0];
            2'b01:   wr_be = 4'b0011 << cur_addr[1:0];
            default: wr_be = 4'b1111;
        endcase
    end

    assign mem_we = enter_resp && cur_we && !cur_fault;
    assign wr_idx = cur_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- load path ----------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    assign rd_word = mem[lat_addr[AW+1:2]];

    always_comb begin
        case (lat_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (lat_size)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = 32'd0;
        endcase
    end

    // ---------------- response ----------------
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && lat_fault;
    assign rsp_rdata = (rsp_valid && !lat_we && !lat_fault) ? load_val : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Three controller instances (WAIT = 1, 3, 0) sharing one clock, driven
//   by directed sequences and random load/store traffic. Expected results
//   come from a byte-level memory model held in the bench.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;
  localparam int N_DUT = 3;

  logic        clk = 1'b0;
  logic        rst       [N_DUT];
  logic        req_valid [N_DUT];
  logic        req_ready [N_DUT];
  logic        req_we    [N_DUT];
  logic [2:0]  req_size  [N_DUT];
  logic [31:0] req_addr  [N_DUT];
  logic [31:0] req_wdata [N_DUT];
  logic        rsp_valid [N_DUT];
  logic [31:0] rsp_rdata [N_DUT];
  logic        rsp_err   [N_DUT];
  logic [1:0]  dbg_state [N_DUT];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    data_memory_ctrl #(
      .DEPTH (DEPTH),
      .WAIT  (g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .dbg_state (dbg_state[g])
    );
  end

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [N_DUT][DEPTH*4];

  task automatic model_access(input int i, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic err);
    int nbytes;
    bit legal;
    bit sgn;
    logic [31:0] val;
    nbytes = 0;
    legal  = 1'b0;
    sgn    = 1'b0;
    case (size)
      3'd0: begin nbytes = 1; legal = 1'b1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; legal = 1'b1; sgn = 1'b1; end
      3'd2: begin nbytes = 4; legal = 1'b1; end
      3'd4: begin nbytes = 1; legal = !we; end
      3'd5: begin nbytes = 2; legal = !we; end
      default: ;
    endcase
    err = !legal || ((addr % nbytes) != 0) || ((addr / 4) >= DEPTH);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < nbytes; k++) ref_mem[i][addr + k] = wdata[8*k +: 8];
      end else begin
        val = 32'd0;
        for (int k = 0; k < nbytes; k++) val = val | (32'(ref_mem[i][addr + k]) << (8*k));
        if (sgn && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8*nbytes));
        rd = val;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic access(input int i, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] erd;
    logic        eerr;
    int          n;
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_size[i]  = size;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    model_access(i, we, size, addr, wdata, erd, eerr);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[i] && n < 50);
    check("latency", 32'(n), 32'(wait_of(i) + 1));
    check("rdata", rsp_rdata[i], erd);
    check("err", 32'(rsp_err[i]), 32'(eerr));
    last_rd  = rsp_rdata[i];
    last_err = rsp_err[i];
    @(negedge clk);
    check("pulse_end", 32'(rsp_valid[i]), 32'd0);
    check("idle_rdata", rsp_rdata[i], 32'd0);
  endtask

  task automatic rand_access(input int i);
    logic [31:0] addr;
    logic [2:0]  size;
    size = 3'($urandom_range(0, 7));
    addr = 32'($urandom_range(0, DEPTH + 1)) * 4 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) begin
      if (size[1:0] == 2'b01) addr[0] = 1'b0;
      if (size[1:0] == 2'b10) addr[1:0] = 2'b00;
    end
    if ($urandom_range(0, 19) == 0) addr[31] = 1'b1;
    access(i, 1'($urandom_range(0, 1)), size, addr, $urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc_cnt;
    int rsp_cnt;
    logic [5:0] rdy_pat;

    for (int i = 0; i < N_DUT; i++) begin
      rst[i]       = 1'b0;
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_size[i]  = 3'd0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      for (int a = 0; a < DEPTH*4; a++) ref_mem[i][a] = 8'd0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check("rst_ready", 32'(req_ready[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rdata", rsp_rdata[i], 32'd0);
      check("rst_err", 32'(rsp_err[i]), 32'd0);
      check("rst_state", 32'(dbg_state[i]), 32'd0);
      rst[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) check("ready_after_rst", 32'(req_ready[i]), 32'd1);

    // ---- directed, WAIT = 1 ----
    access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10", last_rd, 32'hDEADBEEF);
    access(0, 1'b1, 3'b000, 32'h11, 32'h80);
    access(0, 1'b0, 3'b000, 32'h11, 32'h0);
    check("lb_11", last_rd, 32'hFFFFFF80);
    access(0, 1'b0, 3'b100, 32'h11, 32'h0);
    check("lbu_11", last_rd, 32'h00000080);
    access(0, 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10_after_sb", last_rd, 32'hDEAD80EF);
    access(0, 1'b1, 3'b001, 32'h22, 32'h00018001);
    access(0, 1'b0, 3'b001, 32'h22, 32'h0);
    check("lh_22", last_rd, 32'hFFFF8001);
    access(0, 1'b0, 3'b101, 32'h22, 32'h0);
    check("lhu_22", last_rd, 32'h00008001);
    access(0, 1'b0, 3'b010, 32'h20, 32'h0);
    check("lw_20", last_rd, 32'h80010000);
    access(0, 1'b0, 3'b010, 32'h13, 32'h0);
    check("fault_lw_mis", 32'(last_err), 32'd1);
    access(0, 1'b1, 3'b001, 32'h21, 32'hFFFF);
    check("fault_sh_mis", 32'(last_err), 32'd1);
    access(0, 1'b0, 3'b010, 32'(4*DEPTH), 32'h0);
    check("fault_range", 32'(last_err), 32'd1);
    access(0, 1'b0, 3'b011, 32'h10, 32'h0);
    check("fault_f3", 32'(last_err), 32'd1);
    check("fault_f3_rdata", last_rd, 32'd0);
    access(0, 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_10_unchanged", last_rd, 32'hDEAD80EF);

    // ---- reset mid-access, WAIT = 3 ----
    rsp_cnt = 0;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_size[1]  = 3'b010;
    req_addr[1]  = 32'h30;
    req_wdata[1] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid[1]) rsp_cnt++;
    end
    rst[1] = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready[1]), 32'd0);
    check("midrst_state", 32'(dbg_state[1]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid[1]) rsp_cnt++;
    end
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after", 32'(req_ready[1]), 32'd1);
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) rsp_cnt++;
    end
    check("midrst_no_rsp", 32'(rsp_cnt), 32'd0);
    access(1, 1'b0, 3'b010, 32'h30, 32'h0);
    check("midrst_lw_30", last_rd, 32'h0);

    // ---- back-to-back, WAIT = 0 ----
    access(2, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_size[2]  = 3'b010;
    req_addr[2]  = 32'h40;
    acc_cnt = 0;
    rsp_cnt = 0;
    rdy_pat = 6'd0;
    for (int k = 0; k < 6; k++) begin
      rdy_pat[5-k] = req_ready[2];
      if (req_ready[2]) acc_cnt++;
      if (rsp_valid[2]) begin
        rsp_cnt++;
        check("b2b_rdata", rsp_rdata[2], 32'hCAFEF00D);
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    check("b2b_accepts", 32'(acc_cnt), 32'd3);
    check("b2b_rsps", 32'(rsp_cnt), 32'd3);
    check("b2b_ready_pat", 32'(rdy_pat), 32'b101010);
    repeat (2) @(negedge clk);

    // ---- random traffic ----
    for (int k = 0; k < 150; k++) rand_access(0);
    for (int k = 0; k < 40; k++)  rand_access(1);
    for (int k = 0; k < 80; k++)  rand_access(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so a stuck run still ends with a report.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL timeout: got no completion expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
